// File: rtl/sha2_msg_scheduler_if.sv
// Block-in / Wt-out handshake bundle for the SHA-2 message scheduler.
interface sha2_msg_scheduler_if #(
  parameter int WORD_W = 32
);
  logic [16*WORD_W-1:0] block_i;
  logic                 block_v_i;
  logic                 block_ready_o;
  logic [WORD_W-1:0]    wt_o;
  logic [6:0]           wt_idx_o;
  logic                 wt_v_o;
  logic                 wt_ready_i;
  logic                 done_o;

  modport master (
    input  block_i, block_v_i, wt_ready_i,
    output block_ready_o, wt_o, wt_idx_o, wt_v_o, done_o
  );

  modport slave (
    output block_i, block_v_i, wt_ready_i,
    input  block_ready_o, wt_o, wt_idx_o, wt_v_o, done_o
  );
endinterface

// File: rtl/sha2_msg_scheduler.sv
// SHA-2 message schedule generator: 16-word sliding window emitting W[0..ROUNDS-1]
// one word per accepted handshake, with back-to-back block reload on the last word.
module sha2_msg_scheduler #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  sha2_msg_scheduler_if.master  bus
);
  localparam logic [6:0] LAST = 7'(ROUNDS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                   state, state_nxt;
  logic [6:0]               t, t_nxt;
  logic [15:0][WORD_W-1:0]  win, win_nxt;
  logic [WORD_W-1:0]        w_new;
  logic                     accept, last, load, ready;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    else              return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    else              return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // win[k] holds W[t+k], so the new tail word uses window offsets 14, 9, 1, 0
  assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];

  assign accept = (state == RUN) & bus.wt_ready_i;
  assign last   = (t == LAST);
  assign ready  = (state == IDLE) | (accept & last);
  assign load   = bus.block_v_i & ready;

  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    win_nxt   = win;
    if (load) begin
      state_nxt = RUN;
      t_nxt     = '0;
      for (int i = 0; i < 16; i++) win_nxt[i] = bus.block_i[(15-i)*WORD_W +: WORD_W];
    end else if (accept) begin
      if (!last) begin
        t_nxt = t + 7'd1;
        for (int i = 0; i < 15; i++) win_nxt[i] = win[i+1];
        win_nxt[15] = w_new;
      end else begin
        state_nxt = IDLE;
        t_nxt     = '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      t     <= '0;
      win   <= '0;
    end else begin
      state <= state_nxt;
      t     <= t_nxt;
      win   <= win_nxt;
    end
  end

  assign bus.block_ready_o = ready;
  assign bus.wt_o          = win[0];
  assign bus.wt_idx_o      = t;
  assign bus.wt_v_o        = (state == RUN);
  assign bus.done_o        = accept & last;
endmodule

// File: doc/sha2_msg_scheduler.md
SHA2_MSG_SCHEDULER -- requirements
Module: sha2_msg_scheduler

Interface
REQ-001 SHALL have parameter WORD_W, default 32, message word width; legal values 32 (SHA-224/256) and 64 (SHA-384/512).
REQ-002 SHALL have parameter ROUNDS, default 64, number of Wt words produced per block; legal values 64 with WORD_W=32 and 80 with WORD_W=64.
REQ-003 SHALL have one clock and a synchronous, active-high reset, with the ports listed in REQ-004 and REQ-005.
REQ-004 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_i  input  1  synchronous, active-high reset.
REQ-006 block_i  input  16*WORD_W  message block; word 0 in the MSBs, word 15 in the LSBs.
REQ-007 block_v_i  input  1  block_i valid.
REQ-008 block_ready_o  output  1  scheduler accepts a block this cycle.
REQ-009 wt_o  output  WORD_W  current schedule word Wt.
REQ-010 wt_idx_o  output  7  index t of wt_o, range 0..ROUNDS-1.
REQ-011 wt_v_o  output  1  wt_o and wt_idx_o valid.
REQ-012 wt_ready_i  input  1  consumer accepts Wt this cycle.
REQ-013 done_o  output  1  one-cycle pulse in the cycle the final word (t=ROUNDS-1) is accepted.

Function
REQ-014 SHALL implement a two-state FSM with states IDLE and RUN.
REQ-015 SHALL hold a 16-entry window register win[0..15] containing W[t..t+15], and SHALL drive wt_o = win[0] and wt_idx_o = t.
REQ-016 SHALL drive block_ready_o = (IDLE) | (RUN & wt_v_o & wt_ready_i & t==ROUNDS-1).
REQ-017 Load: when block_v_i & block_ready_o, the block SHALL be loaded into win (win[0]=MSB word), t SHALL be set to 0, and the state SHALL be RUN; wt_v_o SHALL be 1 on the next cycle (1-cycle latency).
REQ-018 Accept: in RUN with wt_ready_i=1 and t<ROUNDS-1, the window SHALL shift (win[i]<=win[i+1], i=0..14), win[15]<=Wnew, and t<=t+1.
REQ-019 Wnew SHALL equal sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0], computed modulo 2^WORD_W.
REQ-020 For WORD_W=32: sigma0(x)=ROTR7^ROTR18^SHR3 and sigma1(x)=ROTR17^ROTR19^SHR10.
REQ-021 For WORD_W=64: sigma0(x)=ROTR1^ROTR8^SHR7 and sigma1(x)=ROTR19^ROTR61^SHR6.
REQ-022 Stall: while wt_v_o=1 and wt_ready_i=0, wt_o, wt_idx_o and the window SHALL hold unchanged.
REQ-023 Last word: on acceptance at t=ROUNDS-1, done_o SHALL pulse and the state SHALL go to IDLE, unless a simultaneous load occurs (REQ-024).
REQ-024 Simultaneous last-accept and block_v_i=1: the new block SHALL load, the state SHALL remain RUN with t=0, and done_o SHALL still pulse, giving zero bubble cycles between blocks.
REQ-025 block_v_i while block_ready_o=0 SHALL be ignored, with no state change.
REQ-026 In IDLE, wt_v_o SHALL be 0; wt_ready_i SHALL be ignored when wt_v_o=0.
REQ-027 The t counter SHALL never exceed ROUNDS-1 and SHALL never wrap.

Reset
REQ-028 With reset_i=1 at a clock edge: state<=IDLE, t<=0, all win entries <=0.
REQ-029 Outputs after reset: wt_v_o=0, done_o=0, wt_o=0, wt_idx_o=0, block_ready_o=1.
REQ-030 Reset SHALL take priority over load and accept in the same cycle.
REQ-031 Reset asserted mid-block SHALL abort the block with no done_o pulse.

Verification
REQ-032 SHA-256 "abc": block 0x61626380, 0x0 x14, 0x00000018 -> W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000; all 64 words match a software model; done_o pulses once with wt_idx_o=63.
REQ-033 WORD_W=64, ROUNDS=80, "abc": W0=0x6162638000000000, W15=0x18, W16=0x6162638000000000; all 80 words match the model; done_o pulses with wt_idx_o=79.
REQ-034 Random wt_ready_i backpressure (about 50%) -> word sequence identical to the no-stall run; wt_o is stable during every stall cycle.
REQ-035 Two blocks with block_v_i held high and wt_ready_i=1 -> second block's W0 appears the cycle after first block's t=63 accept; 128 consecutive valid cycles.
REQ-036 reset_i at t=20 -> next cycle wt_v_o=0, wt_idx_o=0, block_ready_o=1, no done_o; a subsequent block produces correct W0.
REQ-037 block_v_i pulsed at t=10 (block_ready_o=0) -> ignored; first block completes correctly.
